// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch controller states
//   INSTR_BYTES   : byte stride between consecutive instruction words
//   NOP           : canonical no-op encoding (addi x0,x0,0)
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    // FETCH_REQ   : free to issue a request (subject to credit)
    // FETCH_WAIT  : one request outstanding, its response will be kept
    // FETCH_DRAIN : one request outstanding, its response will be dropped
    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {pc, instruction} pairs between fetch and decode.
//   push_i/push_pc_i/push_instr_i : write a new entry at the tail
//   pop_i                         : retire the head entry (ignored when empty)
//   flush_i                       : empty the queue after any same-edge pop
//   count_o                       : number of valid entries (0..2)
//   head_valid_o/head_pc_o/head_instr_o : current head, straight from registers
module fetch_queue #(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [PC_WIDTH-1:0]    push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [1:0]             count_o,
    output logic                   head_valid_o,
    output logic [PC_WIDTH-1:0]    head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o
);

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    logic [PC_WIDTH-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [INSTR_WIDTH-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic [1:0]             count_q, count_d;
    logic                   pop_ok;
    logic [1:0]             level;
    logic [1:0]             level_nx;

    // Next-state: pop first, then push into the first free slot, then flush.
    always_comb begin
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        ins0_d   = ins0_q;
        ins1_d   = ins1_q;
        pop_ok   = pop_i && (count_q != 2'd0);
        level    = count_q - (pop_ok ? 2'd1 : 2'd0);
        level_nx = level;

        if (pop_ok) begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
        end

        // A push into a full queue is dropped; the fetch credit rule prevents it.
        if (push_i && (level != 2'd2)) begin
            if (level == 2'd0) begin
                pc0_d  = push_pc_i;
                ins0_d = push_instr_i;
            end else begin
                pc1_d  = push_pc_i;
                ins1_d = push_instr_i;
            end
            level_nx = level + 2'd1;
        end

        count_d = flush_i ? 2'd0 : level_nx;
    end

    // Storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc0_q   <= '0;
            pc1_q   <= '0;
            ins0_q  <= '0;
            ins1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            ins0_q  <= ins0_d;
            ins1_q  <= ins1_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = (count_q != 2'd0);
    assign head_pc_o    = pc0_q;
    assign head_instr_o = ins0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory, buffers responses in a 2-entry queue and
// presents {pc, instruction} to decode. Taken branches redirect the PC and
// flush buffered and in-flight fetches.
//   clk, rst                         : clock, async active-high reset
//   imem_req_valid/ready/addr        : request channel to instruction memory
//   imem_resp_valid/data             : response channel (no back-pressure)
//   branch_taken/branch_target       : redirect from later stages
//   id_ready                         : decode accepts the presented pair
//   if_valid/pc/instruction          : pair presented to decode
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 64,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   id_ready,
    output logic                   if_valid,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instruction
);

    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   tag_pc_q, tag_pc_d;

    logic                  outstanding;
    logic                  credit_ok;
    logic                  req_fire;
    logic                  q_push;
    logic                  q_pop;
    logic [1:0]            q_count;
    logic                  q_head_valid;
    logic [PC_WIDTH-1:0]   q_head_pc;
    logic [INSTR_WIDTH-1:0] q_head_instr;

    // Credit: buffered entries plus the in-flight request must stay below 2.
    assign outstanding = (state_q != FETCH_REQ);
    assign credit_ok   = (({1'b0, q_count} + {2'b00, outstanding}) < 3'd2);

    // Request is held low through reset and on a redirect cycle.
    assign imem_req_valid = !rst && (state_q == FETCH_REQ) && credit_ok && !branch_taken;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign q_pop = q_head_valid && id_ready;

    // Next-state, fetch PC and queue push.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tag_pc_d   = tag_pc_q;
        q_push     = 1'b0;

        // A redirect wins over any other PC update; req cannot fire with it.
        if (branch_taken) begin
            fetch_pc_d = branch_target & ALIGN_MASK;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        case (state_q)
            FETCH_REQ: begin
                if (req_fire) begin
                    state_d  = FETCH_WAIT;
                    tag_pc_d = fetch_pc_q;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_REQ;
                    q_push  = !branch_taken;
                end else if (branch_taken) begin
                    // Response still owed by memory; drop it on arrival.
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_REQ;
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            tag_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
        end
    end

    fetch_queue #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (q_push),
        .push_pc_i    (tag_pc_q),
        .push_instr_i (imem_resp_data),
        .pop_i        (q_pop),
        .flush_i      (branch_taken),
        .count_o      (q_count),
        .head_valid_o (q_head_valid),
        .head_pc_o    (q_head_pc),
        .head_instr_o (q_head_instr)
    );

    assign if_valid    = q_head_valid;
    assign pc          = q_head_pc;
    assign instruction = q_head_instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, transaction-level scoreboard,
// a directed vector table, hand-written corner sequences and random traffic.
module tb_instruction_fetch;
    import fetch_pkg::*;

    localparam int unsigned PW = 64;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [PW-1:0] imem_req_addr;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_data;
    logic          branch_taken;
    logic [PW-1:0] branch_target;
    logic          id_ready;
    logic          if_valid;
    logic [PW-1:0] pc;
    logic [IW-1:0] instruction;

    always #5 clk = ~clk;

    instruction_fetch #(
        .PC_WIDTH    (PW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (64'h0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .pc              (pc),
        .instruction     (instruction)
    );

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] ins;
    } entry_t;

    typedef struct packed {
        logic          req;
        logic          fire;
        logic          ifv;
        logic [PW-1:0] addr;
        logic [PW-1:0] pc;
        logic [IW-1:0] ins;
    } smp_t;

    // Scoreboard: program-order view of what decode should see.
    entry_t        exp_q[$];
    logic [PW-1:0] exp_next_pc;
    logic [PW-1:0] out_addr;
    bit            out_pending;
    bit            out_poison;

    // Memory model state.
    bit            mem_busy;
    int            mem_wait;
    logic [PW-1:0] mem_addr;
    int            lat_cfg;
    bit            lat_rand;

    // Per-cycle stimulus controls.
    logic          st_ready;
    logic          st_id_ready;
    logic          st_br;
    logic [PW-1:0] st_tgt;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return IW'(lo * 32'h9E37_79B1) ^ IW'(a[63:32]) ^ NOP;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_next_pc = 64'h0;
        out_pending = 1'b0;
        out_poison  = 1'b0;
        out_addr    = '0;
        mem_busy    = 1'b0;
        mem_wait    = 0;
        mem_addr    = '0;
    endtask

    // One clock cycle: drive at edge+1, sample/check at edge+2, update after next edge.
    task automatic cycle(output smp_t s);
        bit            fire, pop, resp, br;
        logic [PW-1:0] addr, tgt;
        imem_req_ready  = st_ready;
        id_ready        = st_id_ready;
        branch_taken    = st_br;
        branch_target   = st_tgt;
        imem_resp_valid = mem_busy && (mem_wait == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : IW'(0);
        #1;
        chk("if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("pc", pc, exp_q[0].pc);
            chk("instruction", 64'(instruction), 64'(exp_q[0].ins));
        end
        chk("req_valid", 64'(imem_req_valid),
            64'(!out_pending && (exp_q.size() < 2) && !st_br));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_next_pc);
        chk("push_full", 64'(dut.q_push && (dut.q_count == 2'd2)), 64'd0);
        s.req  = imem_req_valid;
        s.fire = imem_req_valid && imem_req_ready;
        s.ifv  = if_valid;
        s.addr = imem_req_addr;
        s.pc   = pc;
        s.ins  = instruction;
        fire = s.fire;
        pop  = if_valid && id_ready;
        resp = imem_resp_valid;
        br   = st_br;
        addr = imem_req_addr;
        tgt  = st_tgt;
        @(posedge clk);
        #1;
        if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
        if (resp) begin
            if (!out_poison && !br) exp_q.push_back('{pc: out_addr, ins: mem_word(out_addr)});
            out_pending = 1'b0;
        end
        if (br) begin
            exp_q.delete();
            exp_next_pc = tgt & ~64'h3;
            if (out_pending) out_poison = 1'b1;
        end
        if (fire) begin
            out_pending = 1'b1;
            out_poison  = 1'b0;
            out_addr    = addr;
            exp_next_pc = exp_next_pc + 64'd4;
        end
        if (resp) mem_busy = 1'b0;
        else if (mem_busy && mem_wait > 0) mem_wait--;
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = addr;
            mem_wait = (lat_rand ? int'($urandom_range(1, 4)) : lat_cfg) - 1;
        end
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        st_ready        = 1'b1;
        st_id_ready     = 1'b1;
        st_br           = 1'b0;
        st_tgt          = '0;
        lat_cfg         = 1;
        lat_rand        = 1'b0;
        imem_req_ready  = 1'b1;
        id_ready        = 1'b1;
        branch_taken    = 1'b0;
        branch_target   = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_instr", 64'(instruction), 64'd0);
        chk("rst_state", 64'(dut.state_q), 64'(FETCH_REQ));
        rst = 1'b0;
    endtask

    task automatic run_until_fire(input int max, output smp_t s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            cycle(s);
            if (s.fire) ok = 1'b1;
        end
    endtask

    task automatic run_until_ifv(input int max, output smp_t s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            cycle(s);
            if (s.ifv) ok = 1'b1;
        end
    endtask

    typedef struct {
        bit            id_r;
        bit            req_v;
        logic [PW-1:0] addr;
        bit            ifv;
        logic [PW-1:0] pc;
    } vec_t;

    vec_t vt[8];

    initial begin
        smp_t s;
        bit   ok;

        // Startup with a 1-cycle memory and a short decode stall.
        vt[0] = '{1'b1, 1'b1, 64'h0, 1'b0, 64'h0};
        vt[1] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        vt[2] = '{1'b0, 1'b1, 64'h4, 1'b1, 64'h0};
        vt[3] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h0};
        vt[4] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h0};
        vt[5] = '{1'b1, 1'b1, 64'h8, 1'b1, 64'h4};
        vt[6] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        vt[7] = '{1'b1, 1'b1, 64'hC, 1'b1, 64'h8};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            st_id_ready = vt[i].id_r;
            cycle(s);
            chk($sformatf("vec%0d_req_valid", i), 64'(s.req), 64'(vt[i].req_v));
            if (vt[i].req_v) chk($sformatf("vec%0d_addr", i), s.addr, vt[i].addr);
            chk($sformatf("vec%0d_if_valid", i), 64'(s.ifv), 64'(vt[i].ifv));
            if (vt[i].ifv) begin
                chk($sformatf("vec%0d_pc", i), s.pc, vt[i].pc);
                chk($sformatf("vec%0d_instr", i), 64'(s.ins), 64'(mem_word(vt[i].pc)));
            end
        end

        // Decode stalled for 10 cycles: queue fills to 2, requests stop.
        do_reset();
        st_id_ready = 1'b0;
        repeat (10) cycle(s);
        chk("stall_count", 64'(dut.q_count), 64'd2);
        chk("stall_req_valid", 64'(s.req), 64'd0);
        chk("stall_if_valid", 64'(s.ifv), 64'd1);
        chk("stall_pc", s.pc, 64'h0);
        st_id_ready = 1'b1;
        cycle(s);
        chk("release_pc0", s.pc, 64'h0);
        cycle(s);
        chk("release_pc1", s.pc, 64'h4);
        repeat (6) cycle(s);

        // Redirect while waiting on a 3-cycle memory: stale response dropped.
        do_reset();
        lat_cfg = 3;
        cycle(s);
        chk("drain_first_fire", 64'(s.fire), 64'd1);
        st_br  = 1'b1;
        st_tgt = 64'h103;
        cycle(s);
        st_br = 1'b0;
        chk("drain_state", 64'(dut.state_q), 64'(FETCH_DRAIN));
        run_until_fire(10, s, ok);
        chk("drain_req_seen", 64'(ok), 64'd1);
        chk("drain_req_addr", s.addr, 64'h100);
        run_until_ifv(10, s, ok);
        chk("drain_out_seen", 64'(ok), 64'd1);
        chk("drain_out_pc", s.pc, 64'h100);
        repeat (4) cycle(s);

        // Redirect coincident with a response while one entry is buffered.
        do_reset();
        st_id_ready = 1'b0;
        repeat (3) cycle(s);
        chk("coinc_buffered", 64'(dut.q_count), 64'd1);
        st_br  = 1'b1;
        st_tgt = 64'h200;
        cycle(s);
        st_br       = 1'b0;
        st_id_ready = 1'b1;
        cycle(s);
        chk("coinc_if_valid", 64'(s.ifv), 64'd0);
        chk("coinc_req_valid", 64'(s.req), 64'd1);
        chk("coinc_req_addr", s.addr, 64'h200);
        repeat (4) cycle(s);

        // Request back-pressure holds the address; then PC wrap at the top.
        do_reset();
        st_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(s);
            chk($sformatf("hold%0d_addr", i), s.addr, 64'h0);
        end
        st_ready = 1'b1;
        cycle(s);
        chk("hold_fire_addr", s.addr, 64'h0);
        run_until_fire(10, s, ok);
        chk("hold_next_addr", s.addr, 64'h4);
        st_br  = 1'b1;
        st_tgt = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(s);
        st_br = 1'b0;
        run_until_fire(10, s, ok);
        chk("wrap_top_addr", s.addr, 64'hFFFF_FFFF_FFFF_FFFC);
        run_until_fire(10, s, ok);
        chk("wrap_seen", 64'(ok), 64'd1);
        chk("wrap_zero_addr", s.addr, 64'h0);
        repeat (4) cycle(s);

        // Asynchronous reset in the middle of a wait.
        do_reset();
        lat_cfg     = 3;
        st_id_ready = 1'b0;
        repeat (6) cycle(s);
        chk("areset_pre_state", 64'(dut.state_q), 64'(FETCH_WAIT));
        chk("areset_pre_if_valid", 64'(if_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_if_valid", 64'(if_valid), 64'd0);
        chk("areset_req_valid", 64'(imem_req_valid), 64'd0);
        chk("areset_pc", pc, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst         = 1'b0;
        st_id_ready = 1'b1;
        cycle(s);
        chk("areset_first_fire", 64'(s.fire), 64'd1);
        chk("areset_first_addr", s.addr, 64'h0);
        repeat (4) cycle(s);

        // Random traffic against the scoreboard.
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            st_ready    = ($urandom_range(0, 3) != 0);
            st_id_ready = ($urandom_range(0, 3) != 0);
            st_br       = ($urandom_range(0, 19) == 0);
            st_tgt      = {$urandom, $urandom};
            cycle(s);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
